// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter, rise/fall/mode
// edge pulses, sticky flags and saturating event counters, all in the clk domain.

module med_lane #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    input  logic [1:0]           mode,
    input  logic                 clear,
    output logic                 filtered,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 edge_pulse,
    output logic                 sticky,
    output logic [CNT_WIDTH-1:0] event_count
);
    localparam int FCNT_W = $clog2(FILTER_CYCLES) + 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCNT_W-1:0]      fcnt;
    logic                   sync, accept, rise_d, fall_d;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign accept = (sync != filtered) && (fcnt == FCNT_LAST);
    assign rise_d = accept & sync;
    assign fall_d = accept & ~sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= data_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Any return to the current level restarts the persistence count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt     <= '0;
            filtered <= 1'b0;
        end else if (sync == filtered) begin
            fcnt <= '0;
        end else if (fcnt == FCNT_LAST) begin
            fcnt     <= '0;
            filtered <= sync;
        end else begin
            fcnt <= fcnt + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            edge_pulse <= (rise_d & mode[0]) | (fall_d & mode[1]);
        end
    end

    // A pulse coinciding with clear wins: flag stays set, count restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky      <= 1'b0;
            event_count <= '0;
        end else begin
            if (edge_pulse)  sticky <= 1'b1;
            else if (clear)  sticky <= 1'b0;

            if (clear)
                event_count <= edge_pulse ? CNT_WIDTH'(1) : '0;
            else if (edge_pulse && (event_count != '1))
                event_count <= event_count + CNT_WIDTH'(1);
        end
    end
endmodule

module multi_edge_detector #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [2*WIDTH-1:0]         mode,
    input  logic [WIDTH-1:0]           clear,
    output logic [WIDTH-1:0]           filtered,
    output logic [WIDTH-1:0]           rise_pulse,
    output logic [WIDTH-1:0]           fall_pulse,
    output logic [WIDTH-1:0]           edge_pulse,
    output logic [WIDTH-1:0]           sticky,
    output logic [WIDTH*CNT_WIDTH-1:0] event_count,
    output logic                       irq
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        med_lane #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .data_in    (data_in[i]),
            .mode       (mode[2*i+1:2*i]),
            .clear      (clear[i]),
            .filtered   (filtered[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .edge_pulse (edge_pulse[i]),
            .sticky     (sticky[i]),
            .event_count(event_count[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    assign irq = |sticky;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: default 4-channel instance plus a
// 1-channel, 2-bit-counter instance for saturation.

module tb_multi_edge_detector;
    localparam int W  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0]    data_in = '0, clear = '0;
    logic [2*W-1:0]  mode = '0;
    logic [W-1:0]    filtered, rise_pulse, fall_pulse, edge_pulse, sticky;
    logic [W*CW-1:0] event_count;
    logic            irq;

    logic       d2_in = 1'b0, d2_clr = 1'b0;
    logic [1:0] d2_mode = 2'b00;
    logic       d2_filt, d2_rise, d2_fall, d2_edge, d2_sticky, d2_irq;
    logic [1:0] d2_cnt;

    multi_edge_detector dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode(mode), .clear(clear),
        .filtered(filtered), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .edge_pulse(edge_pulse), .sticky(sticky), .event_count(event_count), .irq(irq)
    );

    multi_edge_detector #(.WIDTH(1), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(d2_in), .mode(d2_mode), .clear(d2_clr),
        .filtered(d2_filt), .rise_pulse(d2_rise), .fall_pulse(d2_fall),
        .edge_pulse(d2_edge), .sticky(d2_sticky), .event_count(d2_cnt), .irq(d2_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] din;
        logic [3:0] filt, rise, fall, edg, stk;
        logic       irq;
    } vec_t;

    vec_t rst_tbl[7];
    int   n_vec = 0, n_err = 0;
    int   n_rise[W], n_fall[W], n_filt[W];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_acc();
        for (int i = 0; i < W; i++) begin
            n_rise[i] = 0; n_fall[i] = 0; n_filt[i] = 0;
        end
    endtask

    task automatic step();
        tick();
        for (int i = 0; i < W; i++) begin
            n_rise[i] += int'(rise_pulse[i]);
            n_fall[i] += int'(fall_pulse[i]);
            n_filt[i] += int'(filtered[i]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; data_in = '0; clear = '0; d2_in = 1'b0; d2_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_edge(input int ch, input string name);
        for (int k = 0; k < 20 && !edge_pulse[ch]; k++) tick();
        chk(name, 32'(edge_pulse[ch]), 32'd1);
    endtask

    function automatic logic [7:0] cnt(input int ch);
        logic [W*CW-1:0] v;
        v = event_count;
        return v[ch*CW +: CW];
    endfunction

    initial begin
        // Release with all inputs high: accepted rise at the 5th edge, status one edge later.
        rst_tbl[0] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        rst_tbl[1] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        rst_tbl[2] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        rst_tbl[3] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        rst_tbl[4] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0};
        rst_tbl[5] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1};
        rst_tbl[6] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1};

        // Reset state with inputs high
        rst_n = 1'b0; data_in = 4'hF; mode = 8'hFF;
        tick(); tick(); tick();
        chk("rst_filtered", 32'(filtered), 32'h0);
        chk("rst_pulses", 32'({rise_pulse, fall_pulse, edge_pulse}), 32'h0);
        chk("rst_sticky_irq", 32'({sticky, irq}), 32'h0);
        chk("rst_count", event_count, 32'h0);
        rst_n = 1'b1;
        for (int v = 0; v < 7; v++) begin
            data_in = rst_tbl[v].din;
            tick();
            chk($sformatf("rel%0d_filt", v),   32'(filtered),   32'(rst_tbl[v].filt));
            chk($sformatf("rel%0d_rise", v),   32'(rise_pulse), 32'(rst_tbl[v].rise));
            chk($sformatf("rel%0d_fall", v),   32'(fall_pulse), 32'(rst_tbl[v].fall));
            chk($sformatf("rel%0d_edge", v),   32'(edge_pulse), 32'(rst_tbl[v].edg));
            chk($sformatf("rel%0d_sticky", v), 32'(sticky),     32'(rst_tbl[v].stk));
            chk($sformatf("rel%0d_irq", v),    32'(irq),        32'(rst_tbl[v].irq));
        end
        chk("rel_counts", event_count, 32'h01010101);

        // Glitch rejection on ch0
        do_reset();
        mode = 8'h03;
        clr_acc();
        data_in = 4'h1; step(); step();
        data_in = 4'h0;
        for (int k = 0; k < 10; k++) step();
        chk("glitch2_filt", 32'(n_filt[0]), 32'd0);
        chk("glitch2_rise", 32'(n_rise[0] + n_fall[0]), 32'd0);
        chk("glitch2_count", 32'(cnt(0)), 32'd0);
        clr_acc();
        data_in = 4'h1; step(); step(); step();
        data_in = 4'h0;
        for (int k = 0; k < 12; k++) step();
        chk("pulse3_filt_cycles", 32'(n_filt[0]), 32'd3);
        chk("pulse3_rise", 32'(n_rise[0]), 32'd1);
        chk("pulse3_fall", 32'(n_fall[0]), 32'd1);
        chk("pulse3_count", 32'(cnt(0)), 32'd2);

        // Modes: ch0 rise, ch1 fall, ch2 both, ch3 off
        do_reset();
        mode = 8'b00_11_10_01;
        clr_acc();
        for (int p = 0; p < 3; p++) begin
            data_in = 4'hF;
            for (int k = 0; k < 10; k++) step();
            data_in = 4'h0;
            for (int k = 0; k < 10; k++) step();
        end
        for (int k = 0; k < 8; k++) step();
        chk("modes_counts", event_count, {8'd0, 8'd6, 8'd3, 8'd3});
        chk("modes_sticky", 32'(sticky), 32'h7);
        chk("modes_irq", 32'(irq), 32'd1);
        for (int i = 0; i < W; i++) begin
            chk($sformatf("modes_rise%0d", i), 32'(n_rise[i]), 32'd3);
            chk($sformatf("modes_fall%0d", i), 32'(n_fall[i]), 32'd3);
        end

        // Mid-filter asynchronous reset on ch1 with live status
        data_in = 4'h2;
        tick(); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sticky", 32'({sticky, irq}), 32'h0);
        chk("midrst_count", event_count, 32'h0);
        chk("midrst_filt", 32'(filtered), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        clr_acc();
        step(); step(); step(); step();
        chk("midrst_early_filt", 32'(n_filt[1]), 32'd0);
        chk("midrst_early_rise", 32'(n_rise[1]), 32'd0);
        step();
        chk("midrst_filt5", 32'(filtered[1]), 32'd1);
        chk("midrst_rise5", 32'(rise_pulse[1]), 32'd1);

        // Clear colliding with a pulse on ch2, then a plain clear
        do_reset();
        mode = 8'h30;
        data_in = 4'h4;
        wait_edge(2, "clr_rise_timeout");
        tick();
        chk("clr_pre_count", 32'(cnt(2)), 32'd1);
        data_in = 4'h0;
        wait_edge(2, "clr_fall_timeout");
        clear = 4'h4;
        tick();
        clear = 4'h0;
        chk("clr_coll_sticky", 32'(sticky[2]), 32'd1);
        chk("clr_coll_count", 32'(cnt(2)), 32'd1);
        chk("clr_coll_irq", 32'(irq), 32'd1);
        clear = 4'h4;
        tick();
        clear = 4'h0;
        chk("clr_sticky", 32'(sticky[2]), 32'd0);
        chk("clr_count", 32'(cnt(2)), 32'd0);
        chk("clr_irq", 32'(irq), 32'd0);

        // Saturation on the 2-bit counter instance
        do_reset();
        d2_mode = 2'b11;
        for (int e = 0; e < 5; e++) begin
            d2_in = ~d2_in;
            for (int k = 0; k < 8; k++) tick();
        end
        chk("sat_count5", 32'(d2_cnt), 32'd3);
        for (int e = 0; e < 2; e++) begin
            d2_in = ~d2_in;
            for (int k = 0; k < 8; k++) tick();
        end
        chk("sat_hold", 32'(d2_cnt), 32'd3);
        chk("sat_sticky", 32'({d2_sticky, d2_irq}), 32'h3);
        d2_clr = 1'b1;
        tick();
        d2_clr = 1'b0;
        chk("sat_clear", 32'(d2_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector with input synchronisation, per-channel glitch filtering, per-channel edge-mode selection, sticky event flags and saturating event counters. Each channel carries an asynchronous level input (pushbutton, external strobe, cross-domain flag) into the `clk` domain. It produces clean single-cycle rise, fall and mode-selected edge pulses, plus status that software or a controller can poll and clear. It replaces single-purpose posedge/negedge detectors wherever several inputs or noisy sources are involved.

## Interface
- WIDTH, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flop depth per channel (≥1)
- FILTER_CYCLES, 3: consecutive cycles a new synchronised level must persist before it is accepted (≥1)
- CNT_WIDTH, 8: width of each per-channel event counter (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- data_in  input  WIDTH  raw asynchronous channel levels
- mode  input  2*WIDTH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clear  input  WIDTH  per-channel synchronous clear of sticky flag and counter
- filtered  output  WIDTH  debounced level per channel
- rise_pulse  output  WIDTH  1-cycle pulse on accepted 0→1, independent of mode
- fall_pulse  output  WIDTH  1-cycle pulse on accepted 1→0, independent of mode
- edge_pulse  output  WIDTH  rise/fall pulse masked by channel mode
- sticky  output  WIDTH  latched flag, set by edge_pulse
- event_count  output  WIDTH*CNT_WIDTH  channel i at [(i+1)*CNT_WIDTH-1:i*CNT_WIDTH], saturating count of edge_pulse
- irq  output  1  OR of all sticky bits

## Operation
- Synchroniser: data_in[i] passes through SYNC_STAGES flops; the last stage is sync[i].
- Filter per channel: counter fcnt, width clog2(FILTER_CYCLES)+1. Each edge: if sync≠filtered, then when fcnt==FILTER_CYCLES-1 set filtered←sync and fcnt←0, otherwise fcnt←fcnt+1. If sync==filtered, fcnt←0. Any return to the current level restarts the count.
- rise_pulse[i] registers 1 on the same edge that filtered[i] goes 0→1. fall_pulse[i] registers 1 on the same edge that filtered[i] goes 1→0. Both are 0 on every other edge. They never assert together.
- edge_pulse[i] = (rise_pulse[i] & mode[2i]) | (fall_pulse[i] & mode[2i+1]), registered alongside the rise/fall pulses. Mode is sampled on the edge where the filter updates. A mode change never creates or extends a pulse by itself.
- sticky[i]: set on edge_pulse[i], cleared by clear[i]. When set and clear coincide, set wins.
- event_count[i]: +1 per edge_pulse[i], saturating at 2^CNT_WIDTH-1 with no wrap. clear[i] loads 0. When clear and a pulse coincide, the count loads 1.
- irq is combinational OR of the sticky registers.
- Mode 00 still tracks filtered, rise_pulse and fall_pulse. Only edge_pulse, sticky and count are suppressed.

## Timing
- Reset (rst_n low, asynchronous): sync flops, fcnt, filtered, all pulses, sticky and event_count go to 0, and irq=0. Reset takes effect immediately, including mid-filter, and discards any partial filter count.
- After reset release, a channel held at 1 is treated as a real rising edge once the filter accepts it.
- Latency: a level change first sampled on edge k appears on filtered, and on the corresponding pulses, at edge k+SYNC_STAGES+FILTER_CYCLES-1. With the defaults this is the 5th edge, counting the sampling edge as 1.
- Minimum accepted pulse width at sync: FILTER_CYCLES cycles. Shorter excursions produce no output change.
- The earliest update of sticky and event_count is the edge after edge_pulse is high, so they lag edge_pulse by 1 cycle. clear acts on the next edge.
- Channels are fully independent. Simultaneous events on all channels are all counted.

## Test plan
- Reset: hold rst_n=0 with data_in=4'hF → all outputs 0. Release rst_n, all modes 11 → filtered=4'hF, rise_pulse=4'hF and edge_pulse=4'hF for exactly one cycle at the 5th edge. One cycle later sticky=4'hF, every count=1 and irq=1.
- Glitch rejection: ch0 high for 2 cycles → filtered, pulses and count stay 0. Ch0 high for 3 cycles → filtered[0] high for exactly 3 cycles, then rise_pulse[0] and fall_pulse[0] each fire once.
- Modes: ch0=01, ch1=10, ch2=11, ch3=00, 3 full square-wave periods (10 high/10 low) on all channels → counts 3, 3, 6, 0. sticky=4'b0111. rise_pulse fires 3 times on every channel.
- Clear collision: assert clear[2] on the edge where edge_pulse[2]'s set lands → sticky[2]=1 and count[2]=1. Clear with no event → sticky[2]=0, count[2]=0, and irq follows.
- Saturation with CNT_WIDTH=2, mode 11: 5 edges → count=3 and holds at 3. Clear → 0.
- Mid-operation reset: rst_n pulsed low while ch1 fcnt=2 → all state 0 immediately. After release the stable input needs the full 5-edge latency again, with no early pulse.
